// File: rtl/bamse_defs.sv
// Shared definitions for the bamse interrupt controller: FSM encodings,
// port IDs for the bamse1 ports decoder, and selector index width.
package bamse_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    typedef enum logic [7:0] {
        PORT_IRQ_MASK    = 8'h20,
        PORT_IRQ_EOI     = 8'h21,
        PORT_IRQ_VECTOR  = 8'h22,
        PORT_IRQ_PENDING = 8'h23
    } irq_port_t;

    localparam int IRQ_IDX_W = 3;

endpackage

// File: rtl/bamse_irq_pick.sv
// Combinational winner selector. Fixed priority (source 0 highest) by default;
// BAMSE_IRQ_ROUND_ROBIN_EN switches to round-robin starting after `last`.
module bamse_irq_pick
    import bamse_defs::*;
#(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0]     elig,
    input  logic [IRQ_IDX_W-1:0] last,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    assign valid = |elig;

`ifdef BAMSE_IRQ_ROUND_ROBIN_EN
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    int                 start;

    // Rotate so bit 0 of rot is source last+1; lowest set bit of rot wins.
    always_comb begin
        start = (int'(last) + 1) % N_SRC;
        dbl   = {elig, elig};
        rot   = N_SRC'(dbl >> start);
        idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) idx = IRQ_IDX_W'((start + i) % N_SRC);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) idx = IRQ_IDX_W'(i);
        end
    end
`endif

endmodule

// File: rtl/bamse_irq_ctrl.sv
// Edge-detecting, maskable interrupt controller for the PacoBlaze3 core.
// Optional round-robin selection with BAMSE_IRQ_ROUND_ROBIN_EN.
module bamse_irq_ctrl
    import bamse_defs::*;
#(
    parameter int          N_SRC    = 3,
    parameter logic [7:0]  MASK_RST = 8'hFF
) (
    input  logic             i_Clock,
    input  logic             i_Rst_H,
    input  logic [N_SRC-1:0] i_Irq_Src,
    input  logic             i_Mask_Wr,
    input  logic             i_Eoi_Wr,
    input  logic [7:0]       i_Wr_Data,
    input  logic             i_Int_Ack,
    output logic             o_Interrupt,
    output logic [7:0]       o_Vector,
    output logic [7:0]       o_Pending,
    output logic [7:0]       o_Mask,
    output logic             o_Busy
);

    irq_state_t           state;
    logic [N_SRC-1:0]     prev, pending, pend_nxt, rise, elig, clr;
    logic [7:0]           mask;
    logic                 pick_valid, ack_clr;
    logic [IRQ_IDX_W-1:0] pick_idx, last, win;

    assign rise    = i_Irq_Src & ~prev;
    assign elig    = pending & mask[N_SRC-1:0];
    assign win     = o_Vector[IRQ_IDX_W-1:0];
    assign ack_clr = (state == ST_ASSERT) && i_Int_Ack;
    assign clr     = ack_clr ? (N_SRC'(1) << win) : '0;
    // OR-ing rise after the clear lets a same-cycle rise on the winner survive.
    assign pend_nxt = (pending & ~clr) | rise;

    assign o_Pending = 8'(pending);
    assign o_Mask    = mask;

    bamse_irq_pick #(.N_SRC(N_SRC)) u_pick (
        .elig  (elig),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef BAMSE_IRQ_ROUND_ROBIN_EN
    always_ff @(posedge i_Clock) begin
        if (i_Rst_H)
            last <= IRQ_IDX_W'(N_SRC - 1);
        else if (state == ST_IDLE && pick_valid)
            last <= pick_idx;
    end
`else
    assign last = '0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Rst_H) begin
            state       <= ST_IDLE;
            prev        <= '0;
            pending     <= '0;
            mask        <= MASK_RST;
            o_Interrupt <= 1'b0;
            o_Vector    <= '0;
            o_Busy      <= 1'b0;
        end else begin
            prev    <= i_Irq_Src;
            pending <= pend_nxt;
            if (i_Mask_Wr) mask <= i_Wr_Data;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        o_Vector    <= 8'(pick_idx);
                        o_Interrupt <= 1'b1;
                        o_Busy      <= 1'b1;
                        state       <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (i_Int_Ack) begin
                        o_Interrupt <= 1'b0;
                        state       <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (i_Eoi_Wr) begin
                        o_Busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    o_Interrupt <= 1'b0;
                    o_Busy      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bamse_irq_ctrl.sv
// Directed bench for bamse_irq_ctrl; expected interrupt grants (vector and
// cycle) are queued by the stimulus and checked by an independent monitor.
module tb_bamse_irq_ctrl;

    typedef struct {
        logic [7:0] vec;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] src;
    logic       mask_wr, eoi_wr, int_ack;
    logic [7:0] wr_data;
    logic       irq, busy;
    logic [7:0] vector, pending, mask;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic irq_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bamse_irq_ctrl #(.N_SRC(3), .MASK_RST(8'hFF)) dut (
        .i_Clock     (clk),
        .i_Rst_H     (rst),
        .i_Irq_Src   (src),
        .i_Mask_Wr   (mask_wr),
        .i_Eoi_Wr    (eoi_wr),
        .i_Wr_Data   (wr_data),
        .i_Int_Ack   (int_ack),
        .o_Interrupt (irq),
        .o_Vector    (vector),
        .o_Pending   (pending),
        .o_Mask      (mask),
        .o_Busy      (busy)
    );

    // Monitor: every rising edge of the interrupt line must match a queued grant.
    always @(negedge clk) begin
        if (irq && !irq_q) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL grant: unexpected interrupt vector=%h at cycle %0d", vector, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (vector !== e.vec || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL grant: got vector=%h cycle=%0d, expected vector=%h cycle=%0d",
                             vector, cyc, e.vec, e.cyc);
                end
            end
        end
        irq_q = irq;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_irq(input logic [7:0] v, input int d);
        q.push_back('{vec: v, cyc: cyc + d});
    endtask

    task automatic pulse_src(input logic [2:0] b);
        src = b; tick(); src = '0;
    endtask

    task automatic ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic eoi();
        eoi_wr = 1'b1; tick(); eoi_wr = 1'b0;
    endtask

    task automatic wr_mask(input logic [7:0] d);
        mask_wr = 1'b1; wr_data = d; tick(); mask_wr = 1'b0; wr_data = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; src = '0; mask_wr = 1'b0; eoi_wr = 1'b0; int_ack = 1'b0; wr_data = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_vector", vector, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_busy", {7'b0, busy}, 8'h00);

        // Single source 1 round trip.
        expect_irq(8'h01, 2);
        pulse_src(3'b010);
        chk("t1_pending", pending, 8'h02);
        chk("t1_irq_early", {7'b0, irq}, 8'h00);
        tick();
        chk("t1_irq", {7'b0, irq}, 8'h01);
        chk("t1_vector", vector, 8'h01);
        ack();
        chk("t1_irq_ack", {7'b0, irq}, 8'h00);
        chk("t1_pending_ack", pending, 8'h00);
        chk("t1_busy_svc", {7'b0, busy}, 8'h01);
        eoi();
        chk("t1_busy_eoi", {7'b0, busy}, 8'h00);

        // Simultaneous rises on sources 0 and 2.
`ifdef BAMSE_IRQ_ROUND_ROBIN_EN
        expect_irq(8'h02, 2);
`else
        expect_irq(8'h00, 2);
`endif
        pulse_src(3'b101);
        tick();
        ack();
`ifdef BAMSE_IRQ_ROUND_ROBIN_EN
        chk("t2_pending", pending, 8'h01);
        expect_irq(8'h00, 2);
`else
        chk("t2_pending", pending, 8'h04);
        expect_irq(8'h02, 2);
`endif
        eoi();
        tick();
        chk("t2_irq2", {7'b0, irq}, 8'h01);
        ack();
        eoi();
        chk("t2_pending_end", pending, 8'h00);

        // Masked source stays pending until unmasked.
        wr_mask(8'h06);
        chk("t3_mask", mask, 8'h06);
        pulse_src(3'b001);
        tick(3);
        chk("t3_irq_masked", {7'b0, irq}, 8'h00);
        chk("t3_pending", pending, 8'h01);
        chk("t3_busy", {7'b0, busy}, 8'h00);
        expect_irq(8'h00, 2);
        wr_mask(8'h07);
        tick();
        chk("t3_irq", {7'b0, irq}, 8'h01);
        chk("t3_vector", vector, 8'h00);
        ack();
        eoi();

        // Rise during SERVICE waits for EOI.
        expect_irq(8'h02, 2);
        pulse_src(3'b100);
        tick();
        ack();
        pulse_src(3'b010);
        tick(3);
        chk("t4_pending", pending, 8'h02);
        chk("t4_irq_svc", {7'b0, irq}, 8'h00);
        chk("t4_busy", {7'b0, busy}, 8'h01);
        expect_irq(8'h01, 2);
        eoi();
        tick();
        chk("t4_irq", {7'b0, irq}, 8'h01);
        ack();
        eoi();

        // Level-high source does not retrigger.
        expect_irq(8'h02, 2);
        src = 3'b100;
        tick(2);
        chk("t5_irq", {7'b0, irq}, 8'h01);
        ack();
        eoi();
        tick(95);
        chk("t5_pending_level", pending, 8'h00);
        chk("t5_irq_level", {7'b0, irq}, 8'h00);
        src = '0;
        tick();

        // Rise on the winner in the ack cycle keeps it pending.
        expect_irq(8'h01, 2);
        pulse_src(3'b010);
        tick();
        src = 3'b010; int_ack = 1'b1;
        tick();
        src = '0; int_ack = 1'b0;
        chk("t5_pending_setwins", pending, 8'h02);
        chk("t5_irq_acked", {7'b0, irq}, 8'h00);
        expect_irq(8'h01, 2);
        eoi();
        tick();
        chk("t5_irq_again", {7'b0, irq}, 8'h01);
        ack();
        eoi();
        chk("t5_pending_end", pending, 8'h00);

        // Reset in ASSERT; edge in the reset cycle is lost; later ack ignored.
        expect_irq(8'h00, 2);
        pulse_src(3'b001);
        tick();
        chk("t6_irq_pre", {7'b0, irq}, 8'h01);
        rst = 1'b1; src = 3'b010;
        tick();
        rst = 1'b0; src = '0;
        chk("t6_irq", {7'b0, irq}, 8'h00);
        chk("t6_pending", pending, 8'h00);
        chk("t6_mask", mask, 8'hFF);
        chk("t6_busy", {7'b0, busy}, 8'h00);
        chk("t6_vector", vector, 8'h00);
        ack();
        tick(3);
        chk("t6_busy_ack", {7'b0, busy}, 8'h00);
        chk("t6_irq_ack", {7'b0, irq}, 8'h00);
        chk("t6_pending_lost", pending, 8'h00);

        tick(2);
        chk("drain", 8'(q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
